ccr_unit: RTL and testbench

CCR_UNIT -- requirements
Module: ccr_unit

---
 rtl/ccr_if.sv | 40 ++++
 rtl/ccr_unit.sv | 108 ++++++++++
 tb/tb_ccr_unit.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ccr_if.sv
// Control-signal bundle between the execute stage and the condition-code register unit.
// master drives the per-instruction controls; slave is the ccr_unit side.
interface ccr_if;
    logic       i_stall;
    logic       i_flush;
    logic       i_alu_zero;
    logic       i_alu_neg;
    logic       i_alu_carry;
    logic       i_upd_zn;
    logic       i_upd_c;
    logic       i_setc;
    logic       i_clrc;
    logic       i_jmp_check;
    logic [1:0] i_jmp_cond;
    logic       i_save;
    logic       i_restore;
    logic       o_zero_flag;
    logic       o_negative_flag;
    logic       o_carry_flag;
    logic       o_jmp_taken;
    logic       o_stack_empty;
    logic       o_stack_full;
    logic       o_err;

    modport master (
        output i_stall, i_flush, i_alu_zero, i_alu_neg, i_alu_carry,
               i_upd_zn, i_upd_c, i_setc, i_clrc, i_jmp_check, i_jmp_cond,
               i_save, i_restore,
        input  o_zero_flag, o_negative_flag, o_carry_flag, o_jmp_taken,
               o_stack_empty, o_stack_full, o_err
    );

    modport slave (
        input  i_stall, i_flush, i_alu_zero, i_alu_neg, i_alu_carry,
               i_upd_zn, i_upd_c, i_setc, i_clrc, i_jmp_check, i_jmp_cond,
               i_save, i_restore,
        output o_zero_flag, o_negative_flag, o_carry_flag, o_jmp_taken,
               o_stack_empty, o_stack_full, o_err
    );
endinterface

// File: rtl/ccr_unit.sv
// Condition-code register (Z/N/C) with jump resolution and an interrupt save stack.
// Define FLAG_STACK_EN for a 4-deep LIFO save stack; otherwise a single shadow register is used.
module ccr_unit (
    input  logic  i_clk,
    input  logic  i_rst_n,
    ccr_if.slave  bus
);

`ifdef FLAG_STACK_EN
    localparam int DEPTH = 4;
`else
    localparam int DEPTH = 1;
`endif
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int PTR_W = $clog2(DEPTH + 1);

    logic             z_q;
    logic             n_q;
    logic             c_q;
    logic             err_q;
    logic [PTR_W-1:0] sp_q;
    logic [2:0]       stack_q [DEPTH];

    logic             active;
    logic             sel_flag;
    logic             jmp_taken;
    logic             stack_empty;
    logic             stack_full;
    logic [IDX_W-1:0] push_idx;
    logic [IDX_W-1:0] pop_idx;

    // Jump decision uses the flags as registered before this edge, so it is zero latency.
    always_comb begin
        active   = ~bus.i_stall & ~bus.i_flush;
        sel_flag = 1'b1;
        case (bus.i_jmp_cond)
            2'b00:   sel_flag = 1'b1;
            2'b01:   sel_flag = z_q;
            2'b10:   sel_flag = n_q;
            default: sel_flag = c_q;
        endcase
        jmp_taken   = active & bus.i_jmp_check & sel_flag;
        stack_empty = (sp_q == '0);
        stack_full  = (sp_q == PTR_W'(DEPTH));
        push_idx    = sp_q[IDX_W-1:0];
        pop_idx     = push_idx - IDX_W'(1);
    end

    // Restore beats save, and either one suppresses every per-bit flag write in that cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            z_q   <= 1'b0;
            n_q   <= 1'b0;
            c_q   <= 1'b0;
            err_q <= 1'b0;
            sp_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                stack_q[i] <= 3'b000;
            end
        end else if (active) begin
            if (bus.i_restore) begin
                if (stack_empty) begin
                    err_q <= 1'b1;
                end else begin
                    {c_q, n_q, z_q} <= stack_q[pop_idx];
                    sp_q            <= sp_q - PTR_W'(1);
                end
            end else if (bus.i_save) begin
                if (stack_full) begin
                    err_q <= 1'b1;
                end else begin
                    stack_q[push_idx] <= {c_q, n_q, z_q};
                    sp_q              <= sp_q + PTR_W'(1);
                end
            end else begin
                if (bus.i_upd_zn) begin
                    z_q <= bus.i_alu_zero;
                    n_q <= bus.i_alu_neg;
                end else begin
                    if (jmp_taken && bus.i_jmp_cond == 2'b01) begin
                        z_q <= 1'b0;
                    end
                    if (jmp_taken && bus.i_jmp_cond == 2'b10) begin
                        n_q <= 1'b0;
                    end
                end
                if (bus.i_setc) begin
                    c_q <= 1'b1;
                end else if (bus.i_clrc) begin
                    c_q <= 1'b0;
                end else if (bus.i_upd_c) begin
                    c_q <= bus.i_alu_carry;
                end else if (jmp_taken && bus.i_jmp_cond == 2'b11) begin
                    c_q <= 1'b0;
                end
            end
        end
    end

    assign bus.o_zero_flag     = z_q;
    assign bus.o_negative_flag = n_q;
    assign bus.o_carry_flag    = c_q;
    assign bus.o_jmp_taken     = jmp_taken;
    assign bus.o_stack_empty   = stack_empty;
    assign bus.o_stack_full    = stack_full;
    assign bus.o_err           = err_q;

endmodule

// File: tb/tb_ccr_unit.sv
// Scoreboard bench for ccr_unit: a driver predicts each cycle's outputs from a queue-based
// flag model; a negedge monitor pops predictions and compares them with the DUT.
module tb_ccr_unit;

`ifdef FLAG_STACK_EN
    localparam int DEPTH = 4;
`else
    localparam int DEPTH = 1;
`endif

    typedef struct packed {
        logic       stall;
        logic       flush;
        logic       zero;
        logic       neg;
        logic       carry;
        logic       upd_zn;
        logic       upd_c;
        logic       setc;
        logic       clrc;
        logic       jc;
        logic [1:0] cond;
        logic       save;
        logic       restore;
    } stim_t;

    typedef struct {
        bit jmp;
        bit z;
        bit n;
        bit c;
        bit empty;
        bit full;
        bit err;
    } exp_t;

    logic  clk;
    logic  rst_n;
    ccr_if bus ();

    ccr_unit dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    exp_t     sb[$];
    bit       mz, mn, mc, merr;
    bit [2:0] mstack[$];

    task automatic checkOutput(input string name, input bit actual, input bit expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s at %0t: got %0b, expected %0b", name, $time, actual, expected);
        end
    endtask

    function automatic exp_t snapshot(input bit jmp);
        exp_t e;
        e.jmp   = jmp;
        e.z     = mz;
        e.n     = mn;
        e.c     = mc;
        e.empty = (mstack.size() == 0);
        e.full  = (mstack.size() == DEPTH);
        e.err   = merr;
        return e;
    endfunction

    function automatic void modelReset();
        mz = 0; mn = 0; mc = 0; merr = 0;
        mstack.delete();
    endfunction

    task automatic driveBus(input stim_t s);
        bus.i_stall     = s.stall;
        bus.i_flush     = s.flush;
        bus.i_alu_zero  = s.zero;
        bus.i_alu_neg   = s.neg;
        bus.i_alu_carry = s.carry;
        bus.i_upd_zn    = s.upd_zn;
        bus.i_upd_c     = s.upd_c;
        bus.i_setc      = s.setc;
        bus.i_clrc      = s.clrc;
        bus.i_jmp_check = s.jc;
        bus.i_jmp_cond  = s.cond;
        bus.i_save      = s.save;
        bus.i_restore   = s.restore;
    endtask

    // One instruction cycle: predict outputs visible this cycle, then advance the model.
    task automatic applyStimulus(input stim_t s);
        bit active, flag, taken;
        @(posedge clk);
        #1;
        driveBus(s);
        active = !s.stall && !s.flush;
        case (s.cond)
            2'd0: flag = 1;
            2'd1: flag = mz;
            2'd2: flag = mn;
            default: flag = mc;
        endcase
        taken = active && s.jc && flag;
        sb.push_back(snapshot(taken));
        if (active) begin
            if (s.restore) begin
                if (mstack.size() == 0) merr = 1;
                else {mc, mn, mz} = mstack.pop_back();
            end else if (s.save) begin
                if (mstack.size() == DEPTH) merr = 1;
                else mstack.push_back({mc, mn, mz});
            end else begin
                if (s.upd_zn) begin
                    mz = s.zero;
                    mn = s.neg;
                end else if (taken && s.cond == 2'd1) mz = 0;
                else if (taken && s.cond == 2'd2) mn = 0;
                if (s.setc) mc = 1;
                else if (s.clrc) mc = 0;
                else if (s.upd_c) mc = s.carry;
                else if (taken && s.cond == 2'd3) mc = 0;
            end
        end
    endtask

    // Reset asserted in the middle of a cycle must clear everything before the next edge.
    task automatic midCycleReset();
        @(posedge clk);
        #3;
        driveBus('0);
        rst_n = 1'b0;
        modelReset();
        sb.push_back(snapshot(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        sb.push_back(snapshot(0));
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            checkOutput("jmp_taken", bus.o_jmp_taken, e.jmp);
            checkOutput("zero_flag", bus.o_zero_flag, e.z);
            checkOutput("negative_flag", bus.o_negative_flag, e.n);
            checkOutput("carry_flag", bus.o_carry_flag, e.c);
            checkOutput("stack_empty", bus.o_stack_empty, e.empty);
            checkOutput("stack_full", bus.o_stack_full, e.full);
            checkOutput("err", bus.o_err, e.err);
        end
    end

    initial begin
        stim_t s;
        rst_n = 1'b0;
        driveBus('0);
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        sb.push_back(snapshot(0));

        // ALU flag load: Z=1,N=0,C=1 after one cycle
        s = '0; s.zero = 1; s.carry = 1; s.upd_zn = 1; s.upd_c = 1;
        applyStimulus(s);
        // Taken JZ clears Z; stalled JZ is not taken and Z holds
        s = '0; s.jc = 1; s.cond = 2'd1; s.stall = 1;
        applyStimulus(s);
        s.stall = 0;
        applyStimulus(s);
        applyStimulus('0);
        // setc beats clrc and upd_c; flushed clrc does nothing
        s = '0; s.setc = 1; s.clrc = 1; s.upd_c = 1;
        applyStimulus(s);
        s = '0; s.flush = 1; s.clrc = 1;
        applyStimulus(s);
        // Save 101, disturb the flags, restore
        s = '0; s.upd_zn = 1; s.zero = 1;
        applyStimulus(s);
        s = '0; s.save = 1;
        applyStimulus(s);
        s = '0; s.clrc = 1; s.upd_zn = 1;
        applyStimulus(s);
        s = '0; s.restore = 1;
        applyStimulus(s);
        applyStimulus('0);
        // Overfill and overdrain the stack with distinct entries
        for (int i = 0; i < 5; i++) begin
            s = '0; s.upd_zn = 1; s.upd_c = 1;
            s.zero = i[0]; s.neg = i[1]; s.carry = ~i[0];
            applyStimulus(s);
            s = '0; s.save = 1;
            applyStimulus(s);
        end
        for (int i = 0; i < 5; i++) begin
            s = '0; s.restore = 1; s.save = (i == 1);
            applyStimulus(s);
        end
        applyStimulus('0);
        // Two pushes then asynchronous reset
        s = '0; s.setc = 1;
        applyStimulus(s);
        s = '0; s.save = 1;
        applyStimulus(s);
        applyStimulus(s);
        midCycleReset();

        for (int i = 0; i < 2000; i++) begin
            s = '0;
            s.stall   = ($urandom_range(7) == 0);
            s.flush   = ($urandom_range(7) == 0);
            s.zero    = 1'($urandom);
            s.neg     = 1'($urandom);
            s.carry   = 1'($urandom);
            s.upd_zn  = ($urandom_range(2) == 0);
            s.upd_c   = ($urandom_range(2) == 0);
            s.setc    = ($urandom_range(5) == 0);
            s.clrc    = ($urandom_range(5) == 0);
            s.jc      = ($urandom_range(1) == 0);
            s.cond    = 2'($urandom);
            s.save    = ($urandom_range(3) == 0);
            s.restore = ($urandom_range(3) == 0);
            applyStimulus(s);
            if (i == 1000) midCycleReset();
        end

        repeat (4) @(posedge clk);
        if (sb.size() != 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
